// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: angle encoding (2^32 = full circle), arctangent table, gain.
package cordic_pkg;

   localparam int unsigned ANGLE_W = 32;

   localparam logic [ANGLE_W-1:0] ANG_90  = 32'h4000_0000;
   localparam logic [ANGLE_W-1:0] ANG_180 = 32'h8000_0000;

   // round(K * 2^16), K = prod(sqrt(1 + 2^-2i))
   localparam int unsigned K_Q16 = 107922;

   // round(atan(2^-i) * 2^32 / (2*pi))
   localparam logic [ANGLE_W-1:0] ATAN [32] = '{
      32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
      32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
      32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
      32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
      32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
      32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
      32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
      32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
   };

   typedef enum logic {
      StIdle,
      StRun
   } vec_state_e;

endpackage

// File: rtl/cordic_vector_if.sv
// Start/busy/done handshake and operand/result bus of the vectoring CORDIC.
interface cordic_vector_if
   import cordic_pkg::*;
#(
   parameter int unsigned SZ = 16
);

   logic                   start;
   logic signed [SZ-1:0]   x_in;
   logic signed [SZ-1:0]   y_in;
   logic                   busy;
   logic                   done;
   logic [SZ:0]            mag_out;
   logic [ANGLE_W-1:0]     angle_out;

   modport master (
      output start, x_in, y_in,
      input  busy, done, mag_out, angle_out
   );

   modport slave (
      input  start, x_in, y_in,
      output busy, done, mag_out, angle_out
   );

endinterface

// File: rtl/cordic_vec_stage.sv
// One vectoring micro-rotation: drives y toward zero, accumulating the rotated angle in z.
module cordic_vec_stage
   import cordic_pkg::*;
#(
   parameter int unsigned W = 18
) (
   input  logic signed [W-1:0]   x,
   input  logic signed [W-1:0]   y,
   input  logic [ANGLE_W-1:0]    z,
   input  logic [4:0]            k,
   output logic signed [W-1:0]   x_next,
   output logic signed [W-1:0]   y_next,
   output logic [ANGLE_W-1:0]    z_next
);

   logic signed [W-1:0] x_sh;
   logic signed [W-1:0] y_sh;

   always_comb begin
      x_sh = x >>> k;
      y_sh = y >>> k;
      if (!y[W-1]) begin
         x_next = x + y_sh;
         y_next = y - x_sh;
         z_next = z + ATAN[k];
      end else begin
         x_next = x - y_sh;
         y_next = y + x_sh;
         z_next = z - ATAN[k];
      end
   end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring CORDIC: (x, y) -> (K*|v|, atan2) at one micro-rotation per clock.
module cordic_vector
   import cordic_pkg::*;
#(
   parameter int unsigned SZ   = 16,
   parameter int unsigned ITER = 16
) (
   input logic             clk_100mhz,
   input logic             rst_n,
   cordic_vector_if.slave  bus
);

   // Two guard bits: one for the left-half negation, one for CORDIC gain growth.
   localparam int unsigned W = SZ + 2;
   localparam logic [4:0] K_LAST = 5'(ITER - 1);

   vec_state_e          state_q;
   logic signed [W-1:0] x_q;
   logic signed [W-1:0] y_q;
   logic [ANGLE_W-1:0]  z_q;
   logic [4:0]          k_q;
   logic                zero_q;
   logic                busy_q;
   logic                done_q;
   logic [SZ:0]         mag_q;
   logic [ANGLE_W-1:0]  angle_q;

   logic signed [W-1:0] x_ext;
   logic signed [W-1:0] y_ext;
   logic                left_half;
   logic signed [W-1:0] x_next;
   logic signed [W-1:0] y_next;
   logic [ANGLE_W-1:0]  z_next;

   assign x_ext     = W'(bus.x_in);
   assign y_ext     = W'(bus.y_in);
   assign left_half = bus.x_in[SZ-1];

   cordic_vec_stage #(
      .W (W)
   ) u_stage (
      .x      (x_q),
      .y      (y_q),
      .z      (z_q),
      .k      (k_q),
      .x_next (x_next),
      .y_next (y_next),
      .z_next (z_next)
   );

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         k_q     <= '0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mag_q   <= '0;
         angle_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  // Fold the left half-plane onto the right so the iterations converge.
                  x_q     <= left_half ? -x_ext : x_ext;
                  y_q     <= left_half ? -y_ext : y_ext;
                  z_q     <= left_half ? ANG_180 : '0;
                  k_q     <= '0;
                  zero_q  <= (bus.x_in == '0) && (bus.y_in == '0);
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               x_q <= x_next;
               y_q <= y_next;
               z_q <= z_next;
               if (k_q == K_LAST) begin
                  mag_q   <= zero_q ? '0 : x_next[SZ:0];
                  angle_q <= zero_q ? '0 : z_next;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  k_q <= k_q + 5'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.mag_out   = mag_q;
   assign bus.angle_out = angle_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: real-arithmetic atan2/hypot model, per-cycle handshake compare.
module tb_cordic_vector;
   import cordic_pkg::*;

   localparam int unsigned SZ   = 16;
   localparam int unsigned ITER = 16;
   localparam real    K_GAIN  = 1.646760258;
   localparam real    TWO_PI  = 6.283185307179586;
   localparam real    FULL    = 4294967296.0;
   // Floor shifts on negative y push x up by about 1 LSB per late iteration.
   localparam longint MAG_TOL = 16;
   localparam longint ANG_TOL = 65536;

   typedef struct {
      int     xv;
      int     yv;
      longint acc;
   } op_t;

   logic   clk_100mhz;
   logic   rst_n;
   int     checks = 0;
   int     errors = 0;
   longint edge_cnt = 0;
   op_t    q[$];

   cordic_vector_if #(.SZ(SZ)) bus ();

   cordic_vector #(
      .SZ   (SZ),
      .ITER (ITER)
   ) dut (
      .clk_100mhz (clk_100mhz),
      .rst_n      (rst_n),
      .bus        (bus)
   );

   initial begin
      clk_100mhz = 1'b0;
      forever #5 clk_100mhz = ~clk_100mhz;
   end

   task automatic check(input string name, input bit ok, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic real hypot(input int xv, input int yv);
      return $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
   endfunction

   function automatic longint exp_mag(input int xv, input int yv);
      return longint'(K_GAIN * hypot(xv, yv));
   endfunction

   function automatic logic [31:0] exp_ang(input int xv, input int yv);
      real    a;
      longint l;
      a = $atan2(real'(yv), real'(xv)) / TWO_PI * FULL;
      if (a < 0.0) a = a + FULL;
      l = longint'(a);
      return l[31:0];
   endfunction

   function automatic longint ang_err(input logic [31:0] act, input logic [31:0] exp);
      logic signed [31:0] d;
      d = act - exp;
      return (d < 0) ? -longint'(d) : longint'(d);
   endfunction

   // Truncation noise turns into angle error inversely with vector length.
   function automatic longint ang_tol(input int xv, input int yv);
      return ANG_TOL + longint'(real'(ITER) / hypot(xv, yv) / TWO_PI * FULL);
   endfunction

   function automatic longint mag_err(input longint act, input longint exp);
      return (act > exp) ? act - exp : exp - act;
   endfunction

   // Reference model: which operation is in flight and when it was accepted.
   initial forever begin
      @(posedge clk_100mhz or negedge rst_n);
      if (!rst_n) begin
         q.delete();
         edge_cnt = 0;
      end else begin
         edge_cnt++;
         if (q.size() > 0 && q[0].acc + ITER < edge_cnt) void'(q.pop_front());
         if (bus.start && q.size() == 0)
            q.push_back('{xv: int'(bus.x_in), yv: int'(bus.y_in), acc: edge_cnt});
      end
   end

   // Compare process: handshake every cycle, results on the done cycle.
   initial forever begin
      bit exp_busy;
      bit exp_done;
      @(negedge clk_100mhz);
      if (!rst_n) begin
         check("rst_busy", bus.busy == 1'b0, bus.busy, 0);
         check("rst_done", bus.done == 1'b0, bus.done, 0);
         check("rst_mag", bus.mag_out == '0, bus.mag_out, 0);
         check("rst_angle", bus.angle_out == '0, bus.angle_out, 0);
      end else begin
         exp_busy = 1'b0;
         exp_done = 1'b0;
         if (q.size() > 0) begin
            exp_done = (edge_cnt == q[0].acc + ITER);
            exp_busy = (edge_cnt < q[0].acc + ITER);
         end
         check("busy", bus.busy == exp_busy, bus.busy, exp_busy);
         check("done", bus.done == exp_done, bus.done, exp_done);
         if (exp_done && bus.done) begin
            if (q[0].xv == 0 && q[0].yv == 0) begin
               check("zero_mag", bus.mag_out == '0, bus.mag_out, 0);
               check("zero_angle", bus.angle_out == '0, bus.angle_out, 0);
            end else begin
               check("model_mag",
                     mag_err(longint'(bus.mag_out), exp_mag(q[0].xv, q[0].yv)) <= MAG_TOL,
                     bus.mag_out, exp_mag(q[0].xv, q[0].yv));
               check("model_angle",
                     ang_err(bus.angle_out, exp_ang(q[0].xv, q[0].yv)) <= ang_tol(q[0].xv, q[0].yv),
                     bus.angle_out, exp_ang(q[0].xv, q[0].yv));
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic launch(input int xv, input int yv);
      bus.x_in  = SZ'(xv);
      bus.y_in  = SZ'(yv);
      bus.start = 1'b1;
      @(negedge clk_100mhz);
      bus.start = 1'b0;
   endtask

   task automatic start_op(input int xv, input int yv);
      @(negedge clk_100mhz);
      launch(xv, yv);
   endtask

   // cyc counts negedges since the accepting edge (1 = right after it).
   task automatic wait_done(input int cyc0, output logic [SZ:0] m, output logic [31:0] a,
                            output int cyc, output int busy_cnt);
      bit got;
      got      = 1'b0;
      cyc      = cyc0;
      busy_cnt = 0;
      m        = '0;
      a        = '0;
      while (!got && cyc <= int'(ITER) + 8) begin
         if (bus.done) begin
            got = 1'b1;
            m   = bus.mag_out;
            a   = bus.angle_out;
         end else begin
            if (bus.busy) busy_cnt++;
            @(negedge clk_100mhz);
            cyc++;
         end
      end
      check("done_timeout", got, got, 1);
   endtask

   task automatic lit_result(input string name, input logic [SZ:0] m, input logic [31:0] a,
                             input longint em, input logic [31:0] ea);
      check({name, "_mag"}, mag_err(longint'(m), em) <= MAG_TOL, m, em);
      check({name, "_angle"}, ang_err(a, ea) <= ANG_TOL, a, ea);
   endtask

   initial begin
      logic [SZ:0] m;
      logic [31:0] a;
      int          cyc;
      int          bcnt;
      logic [15:0] rx;
      logic [15:0] ry;

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.x_in  = '0;
      bus.y_in  = '0;
      repeat (3) @(negedge clk_100mhz);
      #3 rst_n = 1'b1;
      @(negedge clk_100mhz);
      check("init_busy", bus.busy == 1'b0, bus.busy, 0);
      check("init_mag", bus.mag_out == '0, bus.mag_out, 0);
      check("init_angle", bus.angle_out == '0, bus.angle_out, 0);

      // Four axis points; K*19429 rounds to 31995.
      start_op(19429, 0);
      wait_done(1, m, a, cyc, bcnt);
      check("latency", cyc == 17, cyc, 17);
      check("busy_cycles", bcnt == 16, bcnt, 16);
      lit_result("east", m, a, 31995, 32'h0);

      start_op(0, 19429);
      wait_done(1, m, a, cyc, bcnt);
      lit_result("north", m, a, 31995, ANG_90);

      start_op(-19429, 0);
      wait_done(1, m, a, cyc, bcnt);
      lit_result("west", m, a, 31995, ANG_180);

      start_op(0, -19429);
      wait_done(1, m, a, cyc, bcnt);
      lit_result("south", m, a, 31995, ANG_90 + ANG_180);

      // Most negative corner: K*32768*sqrt(2) = 76312, must not wrap in 17 bits.
      start_op(-32768, -32768);
      wait_done(1, m, a, cyc, bcnt);
      lit_result("corner", m, a, 76312, 32'hA000_0000);

      start_op(0, 0);
      wait_done(1, m, a, cyc, bcnt);
      check("zero_latency", cyc == 17, cyc, 17);
      check("zero_lit_mag", m == '0, m, 0);
      check("zero_lit_angle", a == '0, a, 0);

      // start during RUN is ignored; the running operand is kept.
      start_op(19429, 0);
      repeat (5) @(negedge clk_100mhz);
      launch(0, -5000);
      wait_done(7, m, a, cyc, bcnt);
      check("ignore_latency", cyc == 17, cyc, 17);
      lit_result("ignore", m, a, 31995, 32'h0);

      // start in the done cycle is accepted.
      launch(-19429, 0);
      wait_done(1, m, a, cyc, bcnt);
      check("b2b_latency", cyc == 17, cyc, 17);
      lit_result("b2b", m, a, 31995, ANG_180);

      // Reset after eight iterations aborts with outputs cleared.
      start_op(0, 19429);
      repeat (8) @(negedge clk_100mhz);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", bus.busy == 1'b0, bus.busy, 0);
      check("abort_done", bus.done == 1'b0, bus.done, 0);
      check("abort_mag", bus.mag_out == '0, bus.mag_out, 0);
      check("abort_angle", bus.angle_out == '0, bus.angle_out, 0);
      @(negedge clk_100mhz);
      #3 rst_n = 1'b1;
      repeat (20) @(negedge clk_100mhz);
      start_op(0, -19429);
      wait_done(1, m, a, cyc, bcnt);
      check("post_rst_latency", cyc == 17, cyc, 17);
      lit_result("post_rst", m, a, 31995, ANG_90 + ANG_180);

      for (int n = 0; n < 40; n++) begin
         int xv;
         int yv;
         do begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            if (n % 10 == 3) rx = 16'h8000;
            xv = int'(signed'(rx));
            yv = int'(signed'(ry));
         end while (longint'(xv) * xv + longint'(yv) * yv < 64'd67108864);
         if (n % 3 != 0) repeat ($urandom_range(1, 3)) @(negedge clk_100mhz);
         launch(xv, yv);
         if ($urandom_range(0, 3) == 0) begin
            repeat (4) @(negedge clk_100mhz);
            launch(int'($urandom_range(0, 1000)), -7);
            wait_done(6, m, a, cyc, bcnt);
         end else begin
            wait_done(1, m, a, cyc, bcnt);
         end
         check("rand_latency", cyc == int'(ITER) + 1, cyc, ITER + 1);
      end

      repeat (4) @(negedge clk_100mhz);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
